// File: rtl/output_src_sequencer_pkg.sv
// ---------------------------------------------------------------
// output_src_sequencer_pkg: shared state and source encodings, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package output_src_sequencer_pkg;

  // Encodings are mirrored by the CPU firmware; do not renumber.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BLANK     = 3'd1,
    SWITCH    = 3'd2,
    RST       = 3'd3,
    WAIT_LOCK = 3'd4,
    SETTLE    = 3'd5
  } seq_state_e;

  localparam logic SRC_SCANCONV = 1'b0;
  localparam logic SRC_VIDEOGEN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/output_src_sequencer_seq_timer.sv
// ---------------------------------------------------------------
// output_src_sequencer_seq_timer: loadable down-counter with zero flag, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module output_src_sequencer_seq_timer #(
  parameter int             CW      = 16,
  parameter logic [CW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Saturates at zero so an idle state never wraps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/output_src_sequencer.sv
// ---------------------------------------------------------------
// output_src_sequencer: glitch-free HDMI source switch sequencer, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module output_src_sequencer
  import output_src_sequencer_pkg::*;
#(
  parameter int CW            = 16,
  parameter int BLANK_CYCLES  = 2700,
  parameter int RST_CYCLES    = 270,
  parameter int SETTLE_CYCLES = 27000,
  parameter int LOCK_TIMEOUT  = 54000
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic src_req,
  input  logic pll_locked,
  input  logic force_blank,
  output logic src_sel,
  output logic blank_out,
  output logic tx_rst_n,
  output logic busy,
  output logic switch_done,
  output logic lock_err
);

  localparam logic [CW-1:0] BLANK_LD  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] RST_LD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LD   = CW'(LOCK_TIMEOUT - 1);

  seq_state_e state_d, state_q;
  logic target_d, target_q;
  logic src_sel_d, src_sel_q;
  logic blank_d, blank_q;
  logic tx_rst_n_d, tx_rst_n_q;
  logic busy_d, busy_q;
  logic done_d, done_q;
  logic lock_err_d, lock_err_q;

  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_zero;

  output_src_sequencer_seq_timer #(
    .CW      (CW),
    .RST_VAL (RST_LD)
  ) u_seq_timer (
    .clk      (clk27),
    .rst_n    (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    src_sel_d  = src_sel_q;
    blank_d    = 1'b1;
    tx_rst_n_d = tx_rst_n_q;
    done_d     = 1'b0;
    lock_err_d = 1'b0;
    timer_load = 1'b0;
    timer_val  = BLANK_LD;

    case (state_q)
      IDLE: begin
        tx_rst_n_d = 1'b1;
        blank_d    = force_blank;
        if (src_req != src_sel_q) begin
          target_d   = src_req;
          state_d    = BLANK;
          blank_d    = 1'b1;
          timer_load = 1'b1;
          timer_val  = BLANK_LD;
        end
      end
      BLANK: begin
        // A withdrawn request aborts before the mux has moved.
        if (src_req == src_sel_q) begin
          state_d = IDLE;
          blank_d = force_blank;
        end else if (timer_zero) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        src_sel_d  = target_q;
        tx_rst_n_d = 1'b0;
        state_d    = RST;
        timer_load = 1'b1;
        timer_val  = RST_LD;
      end
      RST: begin
        tx_rst_n_d = 1'b0;
        if (timer_zero) begin
          tx_rst_n_d = 1'b1;
          timer_load = 1'b1;
          if (target_q == SRC_SCANCONV) begin
            state_d   = WAIT_LOCK;
            timer_val = LOCK_LD;
          end else begin
            state_d   = SETTLE;
            timer_val = SETTLE_LD;
          end
        end
      end
      WAIT_LOCK: begin
        tx_rst_n_d = 1'b1;
        // Timeout still proceeds to SETTLE so the output never stays blanked.
        if (pll_locked || timer_zero) begin
          lock_err_d = !pll_locked;
          state_d    = SETTLE;
          timer_load = 1'b1;
          timer_val  = SETTLE_LD;
        end
      end
      SETTLE: begin
        tx_rst_n_d = 1'b1;
        if (timer_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
          blank_d = force_blank;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_rst_n_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST;
      target_q   <= SRC_VIDEOGEN;
      src_sel_q  <= SRC_VIDEOGEN;
      blank_q    <= 1'b1;
      tx_rst_n_q <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      src_sel_q  <= src_sel_d;
      blank_q    <= blank_d;
      tx_rst_n_q <= tx_rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign src_sel     = src_sel_q;
  assign blank_out   = blank_q;
  assign tx_rst_n    = tx_rst_n_q;
  assign busy        = busy_q;
  assign switch_done = done_q;
  assign lock_err    = lock_err_q;

endmodule

`default_nettype wire

// File: tb/tb_output_src_sequencer.sv
// ---------------------------------------------------------------
// tb_output_src_sequencer: directed bench for the source sequencer, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_output_src_sequencer;

  logic clk27 = 1'b0;
  logic reset_n = 1'b1;
  logic src_req = 1'b1;
  logic pll_locked = 1'b0;
  logic force_blank = 1'b0;
  logic src_sel, blank_out, tx_rst_n, busy, switch_done, lock_err;

  output_src_sequencer #(
    .CW            (16),
    .BLANK_CYCLES  (4),
    .RST_CYCLES    (3),
    .SETTLE_CYCLES (5),
    .LOCK_TIMEOUT  (10)
  ) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .src_req     (src_req),
    .pll_locked  (pll_locked),
    .force_blank (force_blank),
    .src_sel     (src_sel),
    .blank_out   (blank_out),
    .tx_rst_n    (tx_rst_n),
    .busy        (busy),
    .switch_done (switch_done),
    .lock_err    (lock_err)
  );

  always #5 clk27 = ~clk27;

  int n_total = 0;
  int n_bad   = 0;

  int w_idx, n_blank, n_txlow, n_busy, n_done, n_lerr;
  int done_idx, lerr_idx, sel_idx, done_sel;
  logic sel0, prev_sel;
  int n_glitch = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    w_idx = 0; n_blank = 0; n_txlow = 0; n_busy = 0; n_done = 0; n_lerr = 0;
    done_idx = -1; lerr_idx = -1; sel_idx = -1; done_sel = -1;
    sel0 = src_sel; prev_sel = src_sel;
  endtask

  // Samples the current cycle, then advances one clock; repeated n times.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      if (blank_out) n_blank++;
      if (!tx_rst_n) n_txlow++;
      if (busy) n_busy++;
      if (switch_done) begin
        if (n_done == 0) begin
          done_idx = w_idx;
          done_sel = int'(src_sel);
        end
        n_done++;
      end
      if (lock_err) begin
        if (n_lerr == 0) lerr_idx = w_idx;
        n_lerr++;
      end
      if (src_sel != sel0 && sel_idx < 0) sel_idx = w_idx;
      if (src_sel != prev_sel && !blank_out) n_glitch++;
      prev_sel = src_sel;
      w_idx++;
      @(posedge clk27); #1;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_src_sel"},  int'(src_sel), 1);
    check_val({pfx, "_blank"},    int'(blank_out), 1);
    check_val({pfx, "_tx_rst_n"}, int'(tx_rst_n), 0);
    check_val({pfx, "_busy"},     int'(busy), 1);
    check_val({pfx, "_done"},     int'(switch_done), 0);
    check_val({pfx, "_lock_err"}, int'(lock_err), 0);
  endtask

  // Release happens mid-cycle: index 0 is the first RST cycle.
  task automatic check_boot(input string pfx);
    clear_stats();
    watch(12);
    check_val({pfx, "_txlow"},    n_txlow, 3);
    check_val({pfx, "_blank"},    n_blank, 8);
    check_val({pfx, "_busy"},     n_busy, 8);
    check_val({pfx, "_done_n"},   n_done, 1);
    check_val({pfx, "_done_idx"}, done_idx, 8);
    check_val({pfx, "_sel_chg"},  sel_idx, -1);
    check_val({pfx, "_lerr"},     n_lerr, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #2 check_reset_vals("rst");
    repeat (2) @(posedge clk27);
    @(negedge clk27);
    reset_n = 1'b1;
    check_boot("boot");

    // Withdraw the request two cycles into BLANK.
    clear_stats();
    src_req = 1'b0;
    watch(2);
    src_req = 1'b1;
    watch(6);
    check_val("abort_blank",  n_blank, 2);
    check_val("abort_sel",    sel_idx, -1);
    check_val("abort_txlow",  n_txlow, 0);
    check_val("abort_done",   n_done, 0);
    check_val("abort_busy",   n_busy, 2);
    check_val("abort_idle",   int'(busy), 0);

    // Switch to scanconverter with the PLL already locked.
    clear_stats();
    pll_locked = 1'b1;
    src_req = 1'b0;
    watch(18);
    check_val("sc_blank",    n_blank, 14);
    check_val("sc_sel_idx",  sel_idx, 6);
    check_val("sc_txlow",    n_txlow, 3);
    check_val("sc_done_n",   n_done, 1);
    check_val("sc_done_idx", done_idx, 15);
    check_val("sc_lerr",     n_lerr, 0);
    check_val("sc_sel",      int'(src_sel), 0);

    // Back to videogen: no lock wait.
    clear_stats();
    src_req = 1'b1;
    watch(16);
    check_val("vg_blank",    n_blank, 13);
    check_val("vg_done_idx", done_idx, 14);
    check_val("vg_sel",      int'(src_sel), 1);

    // Scanconverter switch with PLL never locking.
    clear_stats();
    pll_locked = 1'b0;
    src_req = 1'b0;
    watch(27);
    check_val("to_blank",    n_blank, 23);
    check_val("to_lerr_n",   n_lerr, 1);
    check_val("to_lerr_idx", lerr_idx, 19);
    check_val("to_done_idx", done_idx, 24);
    check_val("to_sel",      int'(src_sel), 0);

    // Toggle the request during SETTLE of a videogen switch.
    clear_stats();
    pll_locked = 1'b1;
    src_req = 1'b1;
    watch(9);
    src_req = 1'b0;
    watch(1);
    src_req = 1'b1;
    watch(1);
    src_req = 1'b0;
    watch(21);
    check_val("tog_done_n",   n_done, 2);
    check_val("tog_done_idx", done_idx, 14);
    check_val("tog_done_sel", done_sel, 1);
    check_val("tog_blank",    n_blank, 27);
    check_val("tog_sel",      int'(src_sel), 0);

    // Async reset during RST of a scanconverter switch.
    src_req = 1'b1;
    watch(16);
    clear_stats();
    src_req = 1'b0;
    watch(7);
    check_val("mid_sel_pre", int'(src_sel), 0);
    check_val("mid_tx_pre",  int'(tx_rst_n), 0);
    #2 reset_n = 1'b0;
    src_req = 1'b1;
    #1 check_reset_vals("mid");
    repeat (2) @(posedge clk27);
    @(negedge clk27);
    reset_n = 1'b1;
    check_boot("reboot");

    check_val("no_glitch", n_glitch, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
